e1of2_channel_deserializer: RTL and testbench

// Clocked receiver for a 4-phase dual-rail (e1of2) channel of the kind driven by the

---
 rtl/e1of2_channel_deserializer.sv | 226 ++++++++++++++++++++++
 tb/tb_e1of2_channel_deserializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e1of2_channel_deserializer.sv
// e1of2_channel_deserializer
// Receives a 4-phase dual-rail (e1of2) token stream.
// Both rails are synchronized into clk, and the enable handshake is driven back to the sender.
// Received bits are packed LSB-first into WIDTH-bit words.
// Complete words are buffered in a small FIFO and presented on a valid/ready stream.
`timescale 1ns/1ps
module e1of2_channel_deserializer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          l_d0,
    input  logic                          l_d1,
    output logic                          l_e,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          proto_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_NEUTRAL = 2'd1,
        ST_STALL   = 2'd2
    } state_t;

    // Rail synchronizers: stage 0 samples the pin, the last stage feeds the FSM.
    logic [SYNC_STAGES-1:0] d0_sync_r;
    logic [SYNC_STAGES-1:0] d1_sync_r;
    logic                   s0_s;
    logic                   s1_s;

    // Handshake FSM state.
    state_t                 state_r;
    logic [WIDTH-1:0]       word_r;
    logic [CNT_W-1:0]       bitcnt_r;
    logic                   l_e_r;
    logic                   proto_err_r;

    // Word FIFO state.
    logic [WIDTH-1:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [LVL_W-1:0]       count_r;
    logic                   out_valid_r;
    logic [WIDTH-1:0]       out_data_r;

    // Combinational helpers.
    logic                   neutral_s;
    logic                   word_done_s;
    logic                   pop_s;
    logic                   space_s;
    logic                   push_s;
    logic [LVL_W-1:0]       count_nxt_s;
    logic [PTR_W-1:0]       rd_ptr_inc_s;
    logic [WIDTH-1:0]       head_nxt_s;

    assign s0_s         = d0_sync_r[SYNC_STAGES-1];
    assign s1_s         = d1_sync_r[SYNC_STAGES-1];
    assign neutral_s    = !s0_s && !s1_s;
    assign word_done_s  = (bitcnt_r == CNT_DONE);
    assign pop_s        = out_valid_r && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign space_s      = (count_r != LVL_FULL) || pop_s;
    assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE;

    assign l_e          = l_e_r;
    assign proto_err    = proto_err_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign fifo_level   = count_r;

    // Shift both asynchronous rails through the synchronizer chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_sync_r <= {SYNC_STAGES{1'b0}};
            d1_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            d0_sync_r <= {d0_sync_r[SYNC_STAGES-2:0], l_d0};
            d1_sync_r <= {d1_sync_r[SYNC_STAGES-2:0], l_d1};
        end
    end

    // Decide when a completed word enters the FIFO.
    always_comb begin
        push_s = 1'b0;
        case (state_r)
            ST_NEUTRAL: push_s = neutral_s && word_done_s && space_s;
            ST_STALL:   push_s = space_s;
            default:    push_s = 1'b0;
        endcase
    end

    // Compute the next FIFO occupancy from push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + LVL_ONE;
            2'b01:   count_nxt_s = count_r - LVL_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Compute the next head word so that out_data can be a plain register.
    always_comb begin
        head_nxt_s = out_data_r;
        if (push_s && ((count_r == LVL_ZERO) || (pop_s && (count_r == LVL_ONE)))) begin
            head_nxt_s = word_r;
        end else if (pop_s && (count_r > LVL_ONE)) begin
            head_nxt_s = mem_r[rd_ptr_inc_s];
        end else begin
            head_nxt_s = out_data_r;
        end
    end

    // Handshake FSM: accept a token, wait for neutral, hand the word to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACCEPT;
            word_r      <= {WIDTH{1'b0}};
            bitcnt_r    <= CNT_ZERO;
            l_e_r       <= 1'b1;
            proto_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCEPT: begin
                    if (s0_s ^ s1_s) begin
                        // Right shift from the MSB leaves the first bit at bit 0.
                        word_r   <= {s1_s, word_r[WIDTH-1:1]};
                        bitcnt_r <= bitcnt_r + CNT_ONE;
                        state_r  <= ST_NEUTRAL;
                        l_e_r    <= 1'b0;
                    end else if (s0_s && s1_s) begin
                        proto_err_r <= 1'b1;
                        state_r     <= ST_NEUTRAL;
                        l_e_r       <= 1'b0;
                    end else begin
                        state_r <= ST_ACCEPT;
                        l_e_r   <= 1'b1;
                    end
                end
                ST_NEUTRAL: begin
                    if (neutral_s) begin
                        if (word_done_s && !space_s) begin
                            state_r <= ST_STALL;
                            l_e_r   <= 1'b0;
                        end else if (word_done_s) begin
                            word_r   <= {WIDTH{1'b0}};
                            bitcnt_r <= CNT_ZERO;
                            state_r  <= ST_ACCEPT;
                            l_e_r    <= 1'b1;
                        end else begin
                            state_r <= ST_ACCEPT;
                            l_e_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_NEUTRAL;
                        l_e_r   <= 1'b0;
                    end
                end
                ST_STALL: begin
                    if (space_s) begin
                        word_r   <= {WIDTH{1'b0}};
                        bitcnt_r <= CNT_ZERO;
                        state_r  <= ST_ACCEPT;
                        l_e_r    <= 1'b1;
                    end else begin
                        state_r <= ST_STALL;
                        l_e_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_ACCEPT;
                    word_r   <= {WIDTH{1'b0}};
                    bitcnt_r <= CNT_ZERO;
                    l_e_r    <= 1'b1;
                end
            endcase
        end
    end

    // FIFO storage, pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= LVL_ZERO;
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_r;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != LVL_ZERO);
            out_data_r  <= head_nxt_s;
        end
    end

endmodule

// File: tb/tb_e1of2_channel_deserializer.sv
// Directed bench for e1of2_channel_deserializer.
// A 4-phase sender task drives the rails, and a monitor collects the popped words.
`timescale 1ns/1ps
module tb_e1of2_channel_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       l_d0;
    logic       l_d1;
    logic       l_e;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_level;
    logic       proto_err;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int le_viol = 0;
    bit skew_on = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    e1of2_channel_deserializer #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .l_d0(l_d0),
        .l_d1(l_d1),
        .l_e(l_e),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .fifo_level(fifo_level),
        .proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every accepted word; count valid cycles.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            valid_cnt++;
            if (out_ready === 1'b1) got_q.push_back(out_data);
        end
    end

    // Enable must only fall while the sender is holding a data rail.
    always @(negedge l_e) begin
        if (rst_n === 1'b1 && l_d0 !== 1'b1 && l_d1 !== 1'b1) le_viol++;
    end

    function automatic int pick_skew();
        int r;
        if (!skew_on) return 2;
        r = int'($urandom_range(0, 7));
        return (r < 4) ? r + 1 : r + 2;
    endfunction

    // v: 0 -> rail0, 1 -> rail1, 2 -> both rails (protocol error)
    task automatic send_token(input int v, output int fall_n);
        int n;
        int sk;
        sk = pick_skew();
        n = 0;
        do begin
            @(posedge clk);
            #(sk);
            n++;
        end while (l_e !== 1'b1 && n < 2000);
        if (l_e !== 1'b1) check("accept_timeout", {31'd0, l_e}, 32'd1);
        l_d0 = (v == 0 || v == 2);
        l_d1 = (v == 1 || v == 2);
        fall_n = 0;
        do begin
            @(posedge clk);
            #1;
            fall_n++;
        end while (l_e !== 1'b0 && fall_n < 50);
        if (l_e !== 1'b0) check("ack_timeout", {31'd0, l_e}, 32'd0);
        sk = pick_skew();
        #(sk - 1);
        l_d0 = 1'b0;
        l_d1 = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        int f;
        for (int b = first; b <= last; b++) send_token(int'(w[b]), f);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_words(input string tag);
        logic [31:0] g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF;
            check(tag, g, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int f;
        int r;
        logic [7:0] t1_bits;
        rst_n = 1'b0;
        l_d0 = 1'b0;
        l_d1 = 1'b0;
        out_ready = 1'b0;
        wait_cyc(3);

        // Reset state.
        check("rst_l_e", {31'd0, l_e}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // T1: tokens 1,0,1,1,0,0,1,0 -> 8'h4D, latencies of 3 cycles each way.
        out_ready = 1'b1;
        valid_cnt = 0;
        got_q.delete();
        t1_bits = 8'h4D;
        send_token(1, f);
        check("t1_fall_latency", f, 32'd3);
        r = 0;
        do begin
            @(posedge clk);
            #1;
            r++;
        end while (l_e !== 1'b1 && r < 50);
        check("t1_rise_latency", r, 32'd3);
        send_bits(t1_bits, 1, 7);
        wait_cyc(8);
        check("t1_valid_cycles", valid_cnt, 32'd1);
        exp_q.push_back(8'h4D);
        expect_words("t1_word");
        check("t1_level", {29'd0, fifo_level}, 32'd0);
        check("t1_out_valid", {31'd0, out_valid}, 32'd0);

        // T2/T4: five words with out_ready low -> FIFO full plus a stalled word.
        out_ready = 1'b0;
        for (int w = 1; w <= 5; w++) send_bits(8'(w), 0, 7);
        wait_cyc(10);
        check("t2_stall_l_e", {31'd0, l_e}, 32'd0);
        check("t2_full_level", {29'd0, fifo_level}, 32'd4);
        check("t2_full_valid", {31'd0, out_valid}, 32'd1);
        check("t2_head", {24'd0, out_data}, 32'h01);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_level_push_pop", {29'd0, fifo_level}, 32'd4);
        check("t4_l_e_rises", {31'd0, l_e}, 32'd1);
        wait_cyc(10);
        for (int w = 1; w <= 5; w++) exp_q.push_back(8'(w));
        expect_words("t2_order");
        check("t2_drained_level", {29'd0, fifo_level}, 32'd0);

        // T3: both-rails token in the middle of 8'hA5 adds no bit.
        check("t3_proto_before", {31'd0, proto_err}, 32'd0);
        send_bits(8'hA5, 0, 2);
        send_token(2, f);
        check("t3_proto_set", {31'd0, proto_err}, 32'd1);
        send_bits(8'hA5, 3, 7);
        wait_cyc(8);
        exp_q.push_back(8'hA5);
        expect_words("t3_word");
        check("t3_proto_sticky", {31'd0, proto_err}, 32'd1);

        // T5: reset with one word buffered, 3 bits in and l_d1 held high.
        out_ready = 1'b0;
        send_bits(8'h3C, 0, 7);
        wait_cyc(6);
        check("t5_pre_level", {29'd0, fifo_level}, 32'd1);
        send_bits(8'h03, 0, 2);
        r = 0;
        do begin
            @(posedge clk);
            #1;
            r++;
        end while (l_e !== 1'b1 && r < 50);
        l_d1 = 1'b1;
        r = 0;
        do begin
            @(posedge clk);
            #1;
            r++;
        end while (l_e !== 1'b0 && r < 50);
        check("t5_token_acked", {31'd0, l_e}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_l_e", {31'd0, l_e}, 32'd1);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_level", {29'd0, fifo_level}, 32'd0);
        check("t5_rst_proto", {31'd0, proto_err}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        got_q.delete();
        r = 0;
        do begin
            @(posedge clk);
            #1;
            r++;
        end while (l_e !== 1'b0 && r < 50);
        check("t5_rearm_ack", {31'd0, l_e}, 32'd0);
        l_d1 = 1'b0;
        send_bits(8'h5B, 1, 7);
        wait_cyc(8);
        exp_q.push_back(8'h5B);
        expect_words("t5_word");

        // T6: random rail skew within the cycle.
        skew_on = 1'b1;
        send_bits(8'h96, 0, 7);
        send_bits(8'h0F, 0, 7);
        send_bits(8'hE1, 0, 7);
        wait_cyc(8);
        skew_on = 1'b0;
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hE1);
        expect_words("t6_word");
        check("t6_le_fall_without_data", le_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
